// File: rtl/qqspi_target_if.sv
// qqspi_target_if
// Byte-wide bus between the QSPI target and its backing memory.
//   mem_addr  : byte address presented with a strobe
//   mem_wdata : byte to be written, valid with mem_we
//   mem_we    : one-clk write strobe
//   mem_re    : one-clk read strobe
//   mem_rdata : read byte, valid exactly one clk after mem_re
// Modports: master = the QSPI target, slave = the memory.
interface qqspi_target_if;
   logic [23:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      output mem_re,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      input  mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/qqspi_target.sv
// qqspi_target
// Quad/single SPI target bridging an external initiator to a byte memory.
// All SPI pins are oversampled in the clk domain; clk must run at least
// four times faster than sclk.
// Commands: 0x02 single write, 0x03 single read, 0x38 quad write,
// 0xEB quad read with WAIT_CYCLES dummy clocks; anything else is ignored.
// Ports:
//   clk, resetn : system clock, synchronous active-low reset
//   cen         : chip enable (active-low if CEN_NPOL=0, active-high if 1)
//   sclk        : serial clock from the initiator, idles low
//   sio_in      : sio3..sio0 from the pads
//   sio_out     : data to the pads
//   sio_oe      : per-line output enable, 1 = drive
//   mem         : memory bus (qqspi_target_if.master)
module qqspi_target #(
   parameter int CEN_NPOL    = 0,
   parameter int WAIT_CYCLES = 6
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           cen,
   input  logic           sclk,
   input  logic [3:0]     sio_in,
   output logic [3:0]     sio_out,
   output logic [3:0]     sio_oe,
   qqspi_target_if.master mem
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WAIT,
      RDATA,
      WDATA,
      IGNORE
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

   // synchronizers and edge-detect history
   logic       cen_meta_q,  cen_meta_d;
   logic       cen_sync_q,  cen_sync_d;
   logic       cen_prev_q,  cen_prev_d;
   logic       sclk_meta_q, sclk_meta_d;
   logic       sclk_sync_q, sclk_sync_d;
   logic       sclk_prev_q, sclk_prev_d;
   logic [3:0] sio_meta_q,  sio_meta_d;
   logic [3:0] sio_sync_q,  sio_sync_d;

   // protocol state
   state_t      state_q,    state_d;
   logic [7:0]  cmd_q,      cmd_d;
   logic [7:0]  cnt_q,      cnt_d;
   logic [23:0] in_sh_q,    in_sh_d;
   logic [23:0] addr_q,     addr_d;
   logic [7:0]  out_sh_q,   out_sh_d;
   logic [2:0]  ucnt_q,     ucnt_d;
   logic        consumed_q, consumed_d;
   logic        first_q,    first_d;
   logic        rvalid_q,   rvalid_d;
   logic [7:0]  pf_q,       pf_d;
   logic        quad_q,     quad_d;
   logic [3:0]  sio_out_q,  sio_out_d;
   logic [3:0]  sio_oe_q,   sio_oe_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        mem_we_q,   mem_we_d;
   logic        mem_re_q,   mem_re_d;

   // decoded helpers
   logic        cen_act;
   logic        cen_start;
   logic        sclk_rise;
   logic        sclk_fall;
   logic        go_rd;
   logic        cmd_quad;
   logic [7:0]  cmd_byte;
   logic [23:0] addr_quad;
   logic [23:0] addr_single;
   logic [7:0]  sh_next;
   logic [2:0]  ucnt_last;

   // Bits presented for the top unit of a byte: a nibble in quad mode,
   // otherwise the MSB on sio1 with every other line low.
   function automatic logic [3:0] lane_bits(input logic [7:0] b, input logic q);
      lane_bits = q ? b[7:4] : {2'b00, b[7], 1'b0};
   endfunction

   // Two-flop synchronizers; the *_prev flops give edge detection on the
   // synchronized copies so sclk edges and sio data stay aligned.
   always_comb begin
      cen_meta_d  = cen;
      cen_sync_d  = cen_meta_q;
      cen_prev_d  = cen_act;
      sclk_meta_d = sclk;
      sclk_sync_d = sclk_meta_q;
      sclk_prev_d = sclk_sync_q;
      sio_meta_d  = sio_in;
      sio_sync_d  = sio_meta_q;
   end

   assign cen_act   = (CEN_NPOL != 0) ? cen_sync_q : ~cen_sync_q;
   assign cen_start = cen_act & ~cen_prev_q;
   assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

   // Next-state and output logic. Inputs are consumed on sclk rises; read
   // data advances on sclk falls only after the initiator has sampled it.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      in_sh_d     = in_sh_q;
      addr_d      = addr_q;
      out_sh_d    = out_sh_q;
      ucnt_d      = ucnt_q;
      consumed_d  = consumed_q;
      first_d     = first_q;
      rvalid_d    = mem_re_q;
      pf_d        = pf_q;
      quad_d      = quad_q;
      sio_out_d   = 4'b0000;
      sio_oe_d    = 4'b0000;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      go_rd       = 1'b0;
      cmd_quad    = (cmd_q == 8'h38) || (cmd_q == 8'hEB);
      cmd_byte    = {in_sh_q[6:0], sio_sync_q[0]};
      addr_quad   = {in_sh_q[19:0], sio_sync_q};
      addr_single = {in_sh_q[22:0], sio_sync_q[0]};
      sh_next     = quad_q ? {out_sh_q[3:0], 4'h0} : {out_sh_q[6:0], 1'b0};
      ucnt_last   = quad_q ? 3'd1 : 3'd7;

      case (state_q)
         IDLE: begin
            if (cen_start) begin
               state_d = CMD;
               cnt_d   = 8'd0;
               in_sh_d = 24'd0;
            end
         end

         CMD: begin
            if (sclk_rise) begin
               in_sh_d = {16'h0000, cmd_byte};
               cnt_d   = cnt_q + 8'd1;
               if (cnt_q == 8'd7) begin
                  cmd_d   = cmd_byte;
                  cnt_d   = 8'd0;
                  in_sh_d = 24'd0;
                  case (cmd_byte)
                     8'h02, 8'h03, 8'h38, 8'hEB: state_d = ADDR;
                     default:                    state_d = IGNORE;
                  endcase
               end
            end
         end

         ADDR: begin
            if (sclk_rise) begin
               cnt_d   = cnt_q + 8'd1;
               in_sh_d = cmd_quad ? addr_quad : addr_single;
               if ((cmd_quad && cnt_q == 8'd5) || (!cmd_quad && cnt_q == 8'd23)) begin
                  addr_d  = in_sh_d;
                  cnt_d   = 8'd0;
                  in_sh_d = 24'd0;
                  case (cmd_q)
                     8'hEB: begin
                        if (WAIT_CYCLES == 0) go_rd = 1'b1;
                        else                  state_d = WAIT;
                     end
                     8'h03:   go_rd   = 1'b1;
                     default: state_d = WDATA;
                  endcase
               end
            end
         end

         WAIT: begin
            if (sclk_rise) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == WAIT_LAST) begin
                  go_rd = 1'b1;
               end
            end
         end

         RDATA: begin
            sio_oe_d  = sio_oe_q;
            sio_out_d = sio_out_q;
            // First byte arrives from memory: present it at once and
            // prefetch the following byte.
            if (rvalid_q) begin
               if (first_q) begin
                  first_d    = 1'b0;
                  out_sh_d   = mem.mem_rdata;
                  ucnt_d     = 3'd0;
                  sio_out_d  = lane_bits(mem.mem_rdata, quad_q);
                  addr_d     = addr_q + 24'd1;
                  mem_re_d   = 1'b1;
                  mem_addr_d = addr_q + 24'd1;
               end else begin
                  pf_d = mem.mem_rdata;
               end
            end
            if (sclk_rise) begin
               consumed_d = 1'b1;
            end
            // Advance only once the current unit has been sampled, so the
            // fall right after entry does not skip the first unit.
            if (sclk_fall && consumed_q && !first_q) begin
               consumed_d = 1'b0;
               if (ucnt_q == ucnt_last) begin
                  out_sh_d   = pf_q;
                  ucnt_d     = 3'd0;
                  sio_out_d  = lane_bits(pf_q, quad_q);
                  addr_d     = addr_q + 24'd1;
                  mem_re_d   = 1'b1;
                  mem_addr_d = addr_q + 24'd1;
               end else begin
                  out_sh_d  = sh_next;
                  ucnt_d    = ucnt_q + 3'd1;
                  sio_out_d = lane_bits(sh_next, quad_q);
               end
            end
         end

         WDATA: begin
            if (sclk_rise) begin
               in_sh_d = cmd_quad ? addr_quad : addr_single;
               cnt_d   = cnt_q + 8'd1;
               if ((cmd_quad && cnt_q == 8'd1) || (!cmd_quad && cnt_q == 8'd7)) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr_q;
                  mem_wdata_d = in_sh_d[7:0];
                  addr_d      = addr_q + 24'd1;
                  cnt_d       = 8'd0;
                  in_sh_d     = 24'd0;
               end
            end
         end

         IGNORE: begin
            state_d = IGNORE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Entry to the read data phase: fetch the addressed byte and turn the
      // data lanes around.
      if (go_rd) begin
         state_d    = RDATA;
         mem_re_d   = 1'b1;
         mem_addr_d = addr_d;
         first_d    = 1'b1;
         consumed_d = 1'b0;
         ucnt_d     = 3'd0;
         quad_d     = (cmd_q == 8'hEB);
         sio_oe_d   = (cmd_q == 8'hEB) ? 4'b1111 : 4'b0010;
         sio_out_d  = 4'b0000;
      end

      // Chip enable dropping aborts whatever is in flight, including a
      // half-assembled write byte and any pending read result.
      if (state_q != IDLE && !cen_act) begin
         state_d     = IDLE;
         cnt_d       = 8'd0;
         in_sh_d     = 24'd0;
         first_d     = 1'b0;
         consumed_d  = 1'b0;
         rvalid_d    = 1'b0;
         mem_re_d    = 1'b0;
         mem_we_d    = 1'b0;
         mem_addr_d  = mem_addr_q;
         mem_wdata_d = mem_wdata_q;
         sio_oe_d    = 4'b0000;
         sio_out_d   = 4'b0000;
      end
   end

   // State register with synchronous active-low reset. cen_prev_q resets
   // to "active" so a cen already asserted through reset is not taken as a
   // new transaction.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cen_meta_q  <= 1'b0;
         cen_sync_q  <= 1'b0;
         cen_prev_q  <= 1'b1;
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         sio_meta_q  <= 4'b0000;
         sio_sync_q  <= 4'b0000;
         state_q     <= IDLE;
         cmd_q       <= 8'h00;
         cnt_q       <= 8'd0;
         in_sh_q     <= 24'd0;
         addr_q      <= 24'd0;
         out_sh_q    <= 8'h00;
         ucnt_q      <= 3'd0;
         consumed_q  <= 1'b0;
         first_q     <= 1'b0;
         rvalid_q    <= 1'b0;
         pf_q        <= 8'h00;
         quad_q      <= 1'b0;
         sio_out_q   <= 4'b0000;
         sio_oe_q    <= 4'b0000;
         mem_addr_q  <= 24'd0;
         mem_wdata_q <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
      end else begin
         cen_meta_q  <= cen_meta_d;
         cen_sync_q  <= cen_sync_d;
         cen_prev_q  <= cen_prev_d;
         sclk_meta_q <= sclk_meta_d;
         sclk_sync_q <= sclk_sync_d;
         sclk_prev_q <= sclk_prev_d;
         sio_meta_q  <= sio_meta_d;
         sio_sync_q  <= sio_sync_d;
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         in_sh_q     <= in_sh_d;
         addr_q      <= addr_d;
         out_sh_q    <= out_sh_d;
         ucnt_q      <= ucnt_d;
         consumed_q  <= consumed_d;
         first_q     <= first_d;
         rvalid_q    <= rvalid_d;
         pf_q        <= pf_d;
         quad_q      <= quad_d;
         sio_out_q   <= sio_out_d;
         sio_oe_q    <= sio_oe_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
      end
   end

   assign sio_out       = sio_out_q;
   assign sio_oe        = sio_oe_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_re    = mem_re_q;

endmodule

// File: tb/tb_qqspi_target.sv
// tb_qqspi_target
// Directed bench for qqspi_target: an initiator drives SPI transactions,
// a small memory answers the memory bus, and two monitors compare memory
// writes and read-phase pad values against queued expectations.
module tb_qqspi_target;

   localparam int HALF = 8;

   typedef struct packed {
      logic [23:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct packed {
      logic [3:0] oe;
      logic [3:0] out;
   } rd_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cen = 1'b1;
   logic       sclk = 1'b0;
   logic [3:0] sio_drv = 4'h0;
   logic [3:0] sio_out;
   logic [3:0] sio_oe;
   logic       rd_phase = 1'b0;

   int n_compared = 0;
   int n_mismatched = 0;
   int re_count = 0;
   int we_count = 0;
   int re_snap;
   int we_snap;

   wr_t exp_wr[$];
   rd_t exp_rd[$];

   logic [7:0] mem_arr [256];
   bit   [255:0] written;

   qqspi_target_if mem_if();

   qqspi_target #(
      .CEN_NPOL   (0),
      .WAIT_CYCLES(6)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .cen    (cen),
      .sclk   (sclk),
      .sio_in (sio_drv),
      .sio_out(sio_out),
      .sio_oe (sio_oe),
      .mem    (mem_if)
   );

   always #5 clk = ~clk;

   // Memory: unwritten locations read back as (low address byte ^ 0x5A),
   // read data appears one clk after mem_re.
   always @(posedge clk) begin
      if (mem_if.mem_we) begin
         mem_arr[mem_if.mem_addr[7:0]] <= mem_if.mem_wdata;
         written[mem_if.mem_addr[7:0]] <= 1'b1;
      end
      if (mem_if.mem_re) begin
         mem_if.mem_rdata <= written[mem_if.mem_addr[7:0]] ? mem_arr[mem_if.mem_addr[7:0]]
                                                           : (mem_if.mem_addr[7:0] ^ 8'h5A);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clkWait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sclkPulse(input logic [3:0] d);
      sio_drv = d;
      clkWait(HALF);
      sclk = 1'b1;
      clkWait(HALF);
      sclk = 1'b0;
   endtask

   task automatic pushWr(input logic [23:0] a, input logic [7:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_wr.push_back(w);
   endtask

   task automatic pushRd(input logic [3:0] oe, input logic [3:0] out);
      rd_t r;
      r.oe  = oe;
      r.out = out;
      exp_rd.push_back(r);
   endtask

   // Single-lane read of byte b: each bit appears on sio1, MSB first.
   task automatic pushRdSingle(input logic [7:0] b, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         pushRd(4'b0010, {2'b00, b[7 - i], 1'b0});
      end
   endtask

   task automatic checkPending(input string name);
      checkOutput({name, "_pending_wr"}, exp_wr.size(), 0);
      checkOutput({name, "_pending_rd"}, exp_rd.size(), 0);
   endtask

   // One initiator transaction: command on sio0, address (quad for
   // 0x38/0xEB), dummy clocks, then n_data data clocks taken MSB-first
   // from dv. Reads leave sio_in at 0 and flag the data phase.
   task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr,
                                input int n_dummy, input int n_data,
                                input logic [63:0] dv, input bit keep_cen);
      bit quad;
      bit has_addr;
      bit rd;
      quad     = (cmd == 8'h38) || (cmd == 8'hEB);
      has_addr = quad || (cmd == 8'h02) || (cmd == 8'h03);
      rd       = (cmd == 8'h03) || (cmd == 8'hEB);
      cen = 1'b0;
      clkWait(4);
      for (int i = 7; i >= 0; i--) sclkPulse({3'b000, cmd[i]});
      if (has_addr) begin
         if (quad) for (int i = 5; i >= 0; i--) sclkPulse(addr[i*4 +: 4]);
         else      for (int i = 23; i >= 0; i--) sclkPulse({3'b000, addr[i]});
      end
      for (int i = 0; i < n_dummy; i++) sclkPulse(4'h0);
      if (rd) rd_phase = 1'b1;
      for (int i = 0; i < n_data; i++) begin
         if (rd)        sclkPulse(4'h0);
         else if (quad) sclkPulse(dv[63 - 4*i -: 4]);
         else           sclkPulse({3'b000, dv[63 - i]});
      end
      rd_phase = 1'b0;
      if (!keep_cen) begin
         clkWait(4);
         cen     = 1'b1;
         sio_drv = 4'h0;
         clkWait(8);
         checkOutput("oe_after_cen", sio_oe, 0);
      end
   endtask

   // Memory-side monitor: every write strobe is matched against the queue.
   always @(negedge clk) begin : wr_monitor
      wr_t w;
      if (mem_if.mem_re) re_count++;
      if (mem_if.mem_we || mem_if.mem_re) begin
         checkOutput("we_re_exclusive", {31'b0, mem_if.mem_we & mem_if.mem_re}, 0);
      end
      if (mem_if.mem_we) begin
         we_count++;
         if (exp_wr.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                     mem_if.mem_addr, mem_if.mem_wdata);
         end else begin
            w = exp_wr.pop_front();
            checkOutput("wr_addr", mem_if.mem_addr, w.addr);
            checkOutput("wr_data", mem_if.mem_wdata, w.data);
         end
      end
   end

   // Pad monitor: sampled where the initiator samples, on sclk rises.
   always @(posedge sclk) begin : rd_monitor
      rd_t r;
      if (rd_phase) begin
         if (exp_rd.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_read_unit: got out %0h oe %0h, expected none",
                     sio_out, sio_oe);
         end else begin
            r = exp_rd.pop_front();
            checkOutput("rd_oe", sio_oe, r.oe);
            checkOutput("rd_out", sio_out, r.out);
         end
      end else begin
         checkOutput("oe_off", sio_oe, 0);
      end
   end

   initial begin : watchdog
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values
      resetn = 1'b0;
      clkWait(5);
      checkOutput("rst_oe", sio_oe, 0);
      checkOutput("rst_out", sio_out, 0);
      checkOutput("rst_we", mem_if.mem_we, 0);
      checkOutput("rst_re", mem_if.mem_re, 0);
      checkOutput("rst_addr", mem_if.mem_addr, 0);
      checkOutput("rst_wdata", mem_if.mem_wdata, 0);
      resetn = 1'b1;
      clkWait(10);

      $display("[TB] quad write 0x38 @0x10 DEADBEEF");
      pushWr(24'h000010, 8'hDE);
      pushWr(24'h000011, 8'hAD);
      pushWr(24'h000012, 8'hBE);
      pushWr(24'h000013, 8'hEF);
      applyStimulus(8'h38, 24'h000010, 0, 8, 64'hDEADBEEF_00000000, 1'b0);
      checkPending("quad_write");

      $display("[TB] quad read 0xEB @0x10");
      pushRd(4'hF, 4'hD); pushRd(4'hF, 4'hE);
      pushRd(4'hF, 4'hA); pushRd(4'hF, 4'hD);
      pushRd(4'hF, 4'hB); pushRd(4'hF, 4'hE);
      pushRd(4'hF, 4'hE); pushRd(4'hF, 4'hF);
      applyStimulus(8'hEB, 24'h000010, 6, 8, 64'h0, 1'b0);
      checkPending("quad_read");

      $display("[TB] single write 0x02 @0xFFFFFF 1234 (wraps)");
      pushWr(24'hFFFFFF, 8'h12);
      pushWr(24'h000000, 8'h34);
      applyStimulus(8'h02, 24'hFFFFFF, 0, 16, 64'h1234_0000_0000_0000, 1'b0);
      checkPending("single_write");

      $display("[TB] unknown command 0x9F");
      re_snap = re_count;
      we_snap = we_count;
      applyStimulus(8'h9F, 24'h000000, 0, 32, 64'hA5A5A5A5_00000000, 1'b0);
      checkOutput("ignore_re", re_count - re_snap, 0);
      checkOutput("ignore_we", we_count - we_snap, 0);

      $display("[TB] quad write cut after 12 data bits");
      we_snap = we_count;
      pushWr(24'h000040, 8'hA5);
      applyStimulus(8'h38, 24'h000040, 0, 3, 64'hA5C0_0000_0000_0000, 1'b0);
      checkOutput("cut_we_count", we_count - we_snap, 1);
      checkPending("cut_write");

      $display("[TB] single read 0x03 @0x20 with reset in the data phase");
      pushRdSingle(8'h7A, 8);
      pushRdSingle(8'h7B, 4);
      applyStimulus(8'h03, 24'h000020, 0, 12, 64'h0, 1'b1);
      checkPending("read_before_reset");
      clkWait(6);
      re_snap = re_count;
      resetn  = 1'b0;
      clkWait(1);
      checkOutput("rst_mid_oe", sio_oe, 0);
      checkOutput("rst_mid_out", sio_out, 0);
      clkWait(4);
      resetn = 1'b1;
      clkWait(10);
      cen = 1'b1;
      clkWait(10);
      checkOutput("rst_mid_re", re_count - re_snap, 0);

      $display("[TB] single read 0x03 @0x21 after reset");
      pushRdSingle(8'h7B, 8);
      applyStimulus(8'h03, 24'h000021, 0, 8, 64'h0, 1'b0);
      checkPending("read_after_reset");

      clkWait(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
